// File: rtl/shrimp_reg_debug.sv
// shrimp_reg_debug: debug-port initiator for the shrimp register file.
// Takes a byte command stream, performs register-file reads/writes on the
// debug ports and returns response bytes.
//
// Ports:
//   clock, reset          - single clock, async active-high reset
//   cmd_valid/ready/data  - command byte stream in ({op[7:4], r[3:0]})
//   rsp_valid/ready/data  - response byte stream out
//   dbg_r_addr, dbg_r_val - register-file read port (combinational read)
//   dbg_w_addr/val/enable - register-file write port (commits on rising edge)
//   dbg_active            - high while busy; core stalls and yields the ports
//   cmd_err               - one-cycle pulse after an unknown opcode is consumed
module shrimp_reg_debug (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [3:0] dbg_r_addr,
  input  logic [7:0] dbg_r_val,
  output logic [3:0] dbg_w_addr,
  output logic [7:0] dbg_w_val,
  output logic       dbg_w_enable,
  output logic       dbg_active,
  output logic       cmd_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WDATA = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [3:0] OP_READ  = 4'h1;
  localparam logic [3:0] OP_WRITE = 4'h2;
  localparam logic [3:0] OP_DUMP  = 4'h3;

  logic [2:0] state;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic [7:0] rsp_buf;
  logic       dump;
  logic       err_q;
  logic       cmd_fire;

  // cmd_ready depends on state only, so the source never sees a
  // combinational path from cmd_valid.
  assign cmd_ready    = (state == S_IDLE) || (state == S_WDATA);
  assign cmd_fire     = cmd_valid && cmd_ready;
  assign rsp_valid    = (state == S_RESP);
  assign rsp_data     = rsp_buf;
  assign dbg_r_addr   = addr;
  assign dbg_w_addr   = addr;
  assign dbg_w_val    = wdata;
  assign dbg_w_enable = (state == S_WRITE);
  assign dbg_active   = (state != S_IDLE);
  // Registered so the pulse is clean and reads 0 while reset is held.
  assign cmd_err      = err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      addr    <= '0;
      wdata   <= '0;
      rsp_buf <= '0;
      dump    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: if (cmd_fire) begin
          case (cmd_data[7:4])
            OP_READ: begin
              addr  <= cmd_data[3:0];
              state <= S_READ;
            end
            OP_WRITE: begin
              addr  <= cmd_data[3:0];
              state <= S_WDATA;
            end
            OP_DUMP: begin
              addr  <= '0;
              dump  <= 1'b1;
              state <= S_READ;
            end
            default: err_q <= 1'b1;
          endcase
        end
        S_WDATA: if (cmd_fire) begin
          wdata <= cmd_data;
          state <= S_WRITE;
        end
        S_WRITE: begin
          rsp_buf <= {4'h2, addr};
          state   <= S_RESP;
        end
        S_READ: begin
          rsp_buf <= dbg_r_val;
          state   <= S_RESP;
        end
        S_RESP: if (rsp_ready) begin
          // A dump stops at register 15 rather than wrapping to 0.
          if (dump && (addr != 4'hF)) begin
            addr  <= addr + 4'd1;
            state <= S_READ;
          end else begin
            dump  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shrimp_reg_debug.sv
module tb_shrimp_reg_debug;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [3:0] dbg_r_addr;
  logic [7:0] dbg_r_val;
  logic [3:0] dbg_w_addr;
  logic [7:0] dbg_w_val;
  logic       dbg_w_enable;
  logic       dbg_active;
  logic       cmd_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] rf [16];
  logic       preload_req = 1'b0;
  int         wr_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  always #5 clock = ~clock;

  shrimp_reg_debug dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .dbg_r_addr(dbg_r_addr), .dbg_r_val(dbg_r_val),
    .dbg_w_addr(dbg_w_addr), .dbg_w_val(dbg_w_val), .dbg_w_enable(dbg_w_enable),
    .dbg_active(dbg_active), .cmd_err(cmd_err)
  );

  // Register-file model: combinational read, write on rising edge.
  assign dbg_r_val = rf[dbg_r_addr];
  always @(posedge clock) begin
    if (preload_req) begin
      for (int i = 0; i < 16; i++) rf[i] <= 8'h10 + 8'(i);
    end else if (dbg_w_enable) begin
      rf[dbg_w_addr] <= dbg_w_val;
    end
    if (dbg_w_enable) wr_cnt <= wr_cnt + 1;
  end

  // Response monitor: a byte is consumed when valid&&ready at the next edge.
  always @(negedge clock) begin
    if (rsp_valid && rsp_ready) obs_q.push_back(rsp_data);
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_preload();
    preload_req = 1'b1;
    cycles(1);
    preload_req = 1'b0;
  endtask

  // Offers one byte; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_data  = b;
    @(negedge clock);
    while (!cmd_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    n_cmp++;
    if (n >= 100) begin
      n_bad++;
      $display("FAIL send_timeout: byte %h not accepted, cmd_ready=%b required 1", b, cmd_ready);
    end
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_obs();
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < 200) begin
      cycles(1);
      n++;
    end
  endtask

  task automatic test_reset();
    logic [28:0] got;
    int w0;
    @(negedge clock);
    got = {cmd_ready, rsp_valid, rsp_data, dbg_w_enable, dbg_active, cmd_err,
           dbg_r_addr, dbg_w_addr, dbg_w_val};
    n_cmp++;
    if (got !== {1'b1, 1'b0, 8'h00, 3'b000, 4'h0, 4'h0, 8'h00}) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h required %h", got, 29'h10000000);
    end
    cycles(1);
    reset = 1'b0;
    cycles(2);
    // Abort in the middle of a dump.
    do_preload();
    send_byte(8'h30);
    cycles(7);
    w0 = wr_cnt;
    reset = 1'b1;
    #1;
    got = {cmd_ready, rsp_valid, rsp_data, dbg_w_enable, dbg_active, cmd_err,
           dbg_r_addr, dbg_w_addr, dbg_w_val};
    n_cmp++;
    if (got !== {1'b1, 1'b0, 8'h00, 3'b000, 4'h0, 4'h0, 8'h00}) begin
      n_bad++;
      $display("FAIL reset_mid_dump: got %h required %h", got, 29'h10000000);
    end
    obs_q.delete();
    exp_q.delete();
    cycles(2);
    reset = 1'b0;
    cycles(40);
    n_cmp++;
    if (cmd_ready !== 1'b1 || dbg_active !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: cmd_ready=%b dbg_active=%b required 1/0", cmd_ready, dbg_active);
    end
    n_cmp++;
    if (obs_q.size() != 0 || wr_cnt != w0) begin
      n_bad++;
      $display("FAIL reset_stray: responses=%0d writes=%0d required 0/0", obs_q.size(), wr_cnt - w0);
    end
    obs_q.delete();
  endtask

  task automatic test_write_read();
    logic [7:0] e, o;
    send_byte(8'h25);
    exp_q.push_back(8'h25);
    send_byte(8'hA7);
    @(negedge clock);
    n_cmp++;
    if ({dbg_w_enable, dbg_w_addr, dbg_w_val} !== {1'b1, 4'h5, 8'hA7}) begin
      n_bad++;
      $display("FAIL write_strobe: en/addr/val=%b/%h/%h required 1/5/a7", dbg_w_enable, dbg_w_addr, dbg_w_val);
    end
    @(negedge clock);
    n_cmp++;
    if (dbg_w_enable !== 1'b0 || rf[5] !== 8'hA7) begin
      n_bad++;
      $display("FAIL write_commit: en=%b rf5=%h required 0/a7", dbg_w_enable, rf[5]);
    end
    wait_obs();
    cycles(1);
    send_byte(8'h15);
    exp_q.push_back(8'hA7);
    @(negedge clock);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL read_early: rsp_valid=%b required 0 one cycle after command", rsp_valid);
    end
    @(negedge clock);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'hA7) begin
      n_bad++;
      $display("FAIL read_latency: valid/data=%b/%h required 1/a7", rsp_valid, rsp_data);
    end
    wait_obs();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL write_read_rsp: got %h required %h", o, e);
      end
    end
    cycles(2);
  endtask

  task automatic test_backpressure();
    logic [7:0] e, o;
    int n = 0;
    int held_bad = 0;
    rsp_ready = 1'b0;
    send_byte(8'h15);
    exp_q.push_back(8'hA7);
    while (!rsp_valid && n < 20) begin
      cycles(1);
      n++;
    end
    cmd_valid = 1'b1;
    cmd_data  = 8'h13;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (rsp_valid !== 1'b1 || rsp_data !== 8'hA7 || cmd_ready !== 1'b0) held_bad++;
    end
    n_cmp++;
    if (held_bad != 0) begin
      n_bad++;
      $display("FAIL backpressure_hold: %0d unstable cycles, last valid/data/cmd_ready=%b/%h/%b required 1/a7/0",
               held_bad, rsp_valid, rsp_data, cmd_ready);
    end
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_obs();
    cycles(3);
    n_cmp++;
    if (obs_q.size() != 1) begin
      n_bad++;
      $display("FAIL backpressure_count: %0d responses required 1", obs_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL backpressure_rsp: got %h required %h", o, e);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_dump();
    logic [7:0] e, o;
    int cnt = 0;
    do_preload();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h10 + 8'(i));
    send_byte(8'h30);
    @(negedge clock);
    while (dbg_active && cnt < 100) begin
      cnt++;
      @(negedge clock);
    end
    n_cmp++;
    if (cnt != 32) begin
      n_bad++;
      $display("FAIL dump_cycles: busy %0d cycles required 32", cnt);
    end
    cycles(3);
    n_cmp++;
    if (obs_q.size() != 16 || dbg_active !== 1'b0) begin
      n_bad++;
      $display("FAIL dump_count: %0d responses active=%b required 16/0", obs_q.size(), dbg_active);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL dump_rsp: got %h required %h", o, e);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_bad_opcode();
    logic [7:0] e, o;
    send_byte(8'h7F);
    @(negedge clock);
    n_cmp++;
    if (cmd_err !== 1'b1 || dbg_active !== 1'b0) begin
      n_bad++;
      $display("FAIL bad_op_err: cmd_err=%b active=%b required 1/0", cmd_err, dbg_active);
    end
    @(negedge clock);
    n_cmp++;
    if (cmd_err !== 1'b0) begin
      n_bad++;
      $display("FAIL bad_op_pulse: cmd_err=%b required 0 on second cycle", cmd_err);
    end
    cycles(5);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL bad_op_rsp: %0d responses required 0", obs_q.size());
    end
    send_byte(8'h10);
    exp_q.push_back(8'h10);
    wait_obs();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL bad_op_next: got %h required %h", o, e);
      end
    end
    cycles(2);
  endtask

  task automatic test_write_gap();
    logic [7:0] e, o;
    int w0;
    int gap_bad = 0;
    w0 = wr_cnt;
    send_byte(8'h2F);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (dbg_active !== 1'b1 || dbg_w_enable !== 1'b0) gap_bad++;
    end
    n_cmp++;
    if (gap_bad != 0) begin
      n_bad++;
      $display("FAIL gap_active: %0d bad cycles, active/wen=%b/%b required 1/0", gap_bad, dbg_active, dbg_w_enable);
    end
    @(posedge clock);
    #1;
    send_byte(8'h00);
    exp_q.push_back(8'h2F);
    wait_obs();
    cycles(2);
    n_cmp++;
    if (wr_cnt - w0 != 1 || rf[15] !== 8'h00) begin
      n_bad++;
      $display("FAIL gap_write: writes=%0d rf15=%h required 1/00", wr_cnt - w0, rf[15]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL gap_rsp: got %h required %h", o, e);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) rf[i] = 8'h00;
    test_reset();
    test_write_read();
    test_backpressure();
    test_dump();
    test_bad_opcode();
    test_write_gap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
